// File: rtl/sfx_cache_dp.sv
// sfx_cache_dp: 512-byte dual-port instruction cache RAM for the GSU core.
// The RAM is organised as 32 lines of 16 bytes, with one valid bit per byte.
// A line is reported valid only when all 16 of its byte-valid bits are set.
// Port A is the instruction-fetch side and port B is the fill/host side.
// Both ports read and write, and both have registered read data and hit flags.
module sfx_cache_dp #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 8,
    parameter int LINE_BYTES = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic [ADDR_W-1:0]                    addra,
    input  logic [DATA_W-1:0]                    dina,
    input  logic                                 wea,
    output logic [DATA_W-1:0]                    douta,
    output logic                                 hita,
    input  logic [ADDR_W-1:0]                    addrb,
    input  logic [DATA_W-1:0]                    dinb,
    input  logic                                 web,
    output logic [DATA_W-1:0]                    doutb,
    output logic                                 hitb,
    output logic [(1<<ADDR_W)/LINE_BYTES-1:0]    line_valid
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int LINES = DEPTH / LINE_BYTES;
    localparam int OFF_W = $clog2(LINE_BYTES);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]  byte_valid_r;
    logic [DEPTH-1:0]  valid_base_s;
    logic [DEPTH-1:0]  set_a_s;
    logic [DEPTH-1:0]  set_b_s;
    logic [DEPTH-1:0]  valid_nxt_s;
    logic [LINES-1:0]  line_valid_s;
    logic              b_store_s;
    logic [DATA_W-1:0] douta_r;
    logic [DATA_W-1:0] doutb_r;
    logic              hita_r;
    logic              hitb_r;

    // Port B data is dropped when port A writes the same byte in the same cycle.
    assign b_store_s = web && !(wea && (addra == addrb));

    // Reduce each line's 16 byte-valid bits to one line-valid bit.
    always_comb begin
        line_valid_s = {LINES{1'b0}};
        for (int n = 0; n < LINES; n++) begin
            line_valid_s[n] = &byte_valid_r[n*LINE_BYTES +: LINE_BYTES];
        end
    end

    // Next valid state: a flush clears every bit first, then this cycle's writes set theirs.
    always_comb begin
        valid_base_s = flush ? {DEPTH{1'b0}} : byte_valid_r;
        set_a_s      = {{(DEPTH-1){1'b0}}, wea} << addra;
        set_b_s      = {{(DEPTH-1){1'b0}}, web} << addrb;
        valid_nxt_s  = valid_base_s | set_a_s | set_b_s;
    end

    // Byte-valid array: reset clears it and takes priority over flush and writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_valid_r <= {DEPTH{1'b0}};
        end else begin
            byte_valid_r <= valid_nxt_s;
        end
    end

    // RAM data writes. These are not gated by reset, and port A wins a same-address collision.
    always_ff @(posedge clk) begin
        if (wea) begin
            mem_r[addra] <= dina;
        end
        if (b_store_s) begin
            mem_r[addrb] <= dinb;
        end
    end

    // Registered read data and hit flags. The array is read before this edge's writes land.
    always_ff @(posedge clk) begin
        if (rst) begin
            douta_r <= {DATA_W{1'b0}};
            doutb_r <= {DATA_W{1'b0}};
            hita_r  <= 1'b0;
            hitb_r  <= 1'b0;
        end else begin
            douta_r <= mem_r[addra];
            doutb_r <= mem_r[addrb];
            hita_r  <= line_valid_s[addra[ADDR_W-1:OFF_W]];
            hitb_r  <= line_valid_s[addrb[ADDR_W-1:OFF_W]];
        end
    end

    assign douta      = douta_r;
    assign doutb      = doutb_r;
    assign hita       = hita_r;
    assign hitb       = hitb_r;
    assign line_valid = line_valid_s;

endmodule

// File: tb/tb_sfx_cache_dp.sv
// tb_sfx_cache_dp: scoreboard bench for sfx_cache_dp.
// Stimulus pushes the expected read response for each checked access.
// A separate monitor pops each entry and compares it on the falling edge
// of the cycle where the registered output appears.
module tb_sfx_cache_dp;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [8:0]  addra;
    logic [7:0]  dina;
    logic        wea;
    logic [7:0]  douta;
    logic        hita;
    logic [8:0]  addrb;
    logic [7:0]  dinb;
    logic        web;
    logic [7:0]  doutb;
    logic        hitb;
    logic [31:0] line_valid;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int         due;
        bit         port_b;
        bit         chk_data;
        logic [7:0] data;
        logic       hit;
    } exp_t;

    exp_t sb_q[$];

    sfx_cache_dp dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .addra      (addra),
        .dina       (dina),
        .wea        (wea),
        .douta      (douta),
        .hita       (hita),
        .addrb      (addrb),
        .dinb       (dinb),
        .web        (web),
        .doutb      (doutb),
        .hitb       (hitb),
        .line_valid (line_valid)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used to time scoreboard entries
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Record the response expected one cycle after the access now on the pins
    task automatic expect_rd(input bit pb, input bit cd, input logic [7:0] d, input logic h);
        exp_t e;
        e.due      = cyc + 1;
        e.port_b   = pb;
        e.chk_data = cd;
        e.data     = d;
        e.hit      = h;
        sb_q.push_back(e);
    endtask

    // Monitor: compare every scoreboard entry whose response is due now
    always @(negedge clk) begin
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            if (e.port_b) begin
                if (e.chk_data) chk("doutb", {24'h0, doutb}, {24'h0, e.data});
                chk("hitb", {31'h0, hitb}, {31'h0, e.hit});
            end else begin
                if (e.chk_data) chk("douta", {24'h0, douta}, {24'h0, e.data});
                chk("hita", {31'h0, hita}, {31'h0, e.hit});
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0;
        addra = 9'h000; dina = 8'h00; wea = 1'b0;
        addrb = 9'h000; dinb = 8'h00; web = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_douta", {24'h0, douta}, 32'h0);
        chk("rst_doutb", {24'h0, doutb}, 32'h0);
        chk("rst_hita", {31'h0, hita}, 32'h0);
        chk("rst_hitb", {31'h0, hitb}, 32'h0);
        chk("rst_line_valid", line_valid, 32'h0);

        // First read after reset: no line is valid yet
        addra = 9'h000;
        expect_rd(1'b0, 1'b0, 8'h00, 1'b0);
        tick();

        // Fill line 2 from port B; none of these accesses can hit
        web = 1'b1;
        for (int i = 0; i < 16; i++) begin
            addrb = 9'(9'h020 + i);
            dinb  = 8'(8'h10 + i);
            expect_rd(1'b1, 1'b0, 8'h00, 1'b0);
            tick();
            if (i == 14) chk("lv2_after_15", {31'h0, line_valid[2]}, 32'h0);
            if (i == 15) chk("lv2_after_16", {31'h0, line_valid[2]}, 32'h1);
        end
        web = 1'b0;
        addra = 9'h025;
        expect_rd(1'b0, 1'b1, 8'h15, 1'b1);
        tick();

        // Write collision at 0x1FF: port A's data wins
        wea = 1'b1; web = 1'b1;
        addra = 9'h1FF; addrb = 9'h1FF; dina = 8'hAA; dinb = 8'h55;
        tick();
        wea = 1'b0; web = 1'b0;
        expect_rd(1'b0, 1'b1, 8'hAA, 1'b0);
        expect_rd(1'b1, 1'b1, 8'hAA, 1'b0);
        tick();
        chk("lv_after_collision", line_valid, 32'h0000_0004);
        // Only byte 15 of line 31 is valid, so 15 more writes complete the line
        web = 1'b1;
        for (int i = 0; i < 15; i++) begin
            addrb = 9'(9'h1F0 + i);
            dinb  = 8'(8'hE0 + i);
            tick();
            if (i == 13) chk("lv31_after_14", {31'h0, line_valid[31]}, 32'h0);
            if (i == 14) chk("lv31_after_15", {31'h0, line_valid[31]}, 32'h1);
        end

        // Read-first on both ports
        addrb = 9'h040; dinb = 8'h11;
        tick();
        web = 1'b0;
        wea = 1'b1; addra = 9'h040; dina = 8'h22;
        expect_rd(1'b0, 1'b1, 8'h11, 1'b0);
        expect_rd(1'b1, 1'b1, 8'h11, 1'b0);
        tick();
        wea = 1'b0;
        expect_rd(1'b1, 1'b1, 8'h22, 1'b0);
        tick();

        // Flush with a coincident port B write to 0x020; hits in this cycle see the pre-flush state
        flush = 1'b1; web = 1'b1; addrb = 9'h020; dinb = 8'h10; addra = 9'h025;
        expect_rd(1'b0, 1'b1, 8'h15, 1'b1);
        expect_rd(1'b1, 1'b1, 8'h10, 1'b1);
        tick();
        flush = 1'b0; web = 1'b0;
        chk("lv_after_flush", line_valid, 32'h0);
        expect_rd(1'b0, 1'b1, 8'h15, 1'b0);
        tick();
        web = 1'b1;
        for (int i = 1; i < 16; i++) begin
            addrb = 9'(9'h020 + i);
            dinb  = 8'(8'h10 + i);
            tick();
            if (i == 14) chk("lv2_refill_14", {31'h0, line_valid[2]}, 32'h0);
            if (i == 15) chk("lv2_refill_15", {31'h0, line_valid[2]}, 32'h1);
        end

        // Fill line 5, then reset mid-operation while port A writes 0x060
        for (int i = 0; i < 16; i++) begin
            addrb = 9'(9'h050 + i);
            dinb  = 8'(8'hC0 + i);
            tick();
        end
        web = 1'b0;
        chk("lv_lines_2_5", line_valid, 32'h0000_0024);
        addra = 9'h025;
        expect_rd(1'b0, 1'b1, 8'h15, 1'b1);
        tick();
        rst = 1'b1; wea = 1'b1; addra = 9'h060; dina = 8'h77; addrb = 9'h050;
        tick();
        rst = 1'b0; wea = 1'b0;
        chk("rst2_douta", {24'h0, douta}, 32'h0);
        chk("rst2_doutb", {24'h0, doutb}, 32'h0);
        chk("rst2_hita", {31'h0, hita}, 32'h0);
        chk("rst2_hitb", {31'h0, hitb}, 32'h0);
        chk("rst2_line_valid", line_valid, 32'h0);
        addra = 9'h050; addrb = 9'h060;
        expect_rd(1'b0, 1'b1, 8'hC0, 1'b0);
        expect_rd(1'b1, 1'b1, 8'h77, 1'b0);
        tick();
        tick();
        tick();
        chk("scoreboard_drained", sb_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sfx_cache_dp.md
Name: sfx_cache_dp

Overview:
512-byte dual-port instruction cache RAM for the GSU (SuperFX) core. It holds 32 lines of 16 bytes each. Every byte has a valid bit, and a line is valid only when all 16 of its bytes are valid. Port A is the core's instruction-fetch side; port B is the fill/host side. Both ports are full read/write.

Parameters:
ADDR_W, 9, byte address width (512 bytes)
DATA_W, 8, data width
LINE_BYTES, 16, bytes per line (line index = addr[8:4], offset = addr[3:0])

Ports:
clk  in  1  single clock for both ports
rst  in  1  synchronous reset, active-high
flush  in  1  invalidate all lines (CBR write / cache clear)
addra  in  9  port A byte address
dina  in  8  port A write data
wea  in  1  port A write enable
douta  out  8  port A registered read data
hita  out  1  registered: the line addressed by addra was fully valid
addrb  in  9  port B byte address
dinb  in  8  port B write data
web  in  1  port B write enable
doutb  out  8  port B registered read data
hitb  out  1  registered: the line addressed by addrb was fully valid
line_valid  out  32  bit n = all 16 byte-valid bits of line n are set (combinational from the valid state)

Behaviour:
- One clock and a synchronous active-high reset, as already decided. Everything below is sampled on the rising edge of clk.
- Reset:
  - douta, doutb, hita and hitb go to 0.
  - All 512 byte-valid bits are cleared, so line_valid = 0.
  - RAM data contents are not cleared.
- Read latency is one cycle on both ports. The address is sampled at edge N; dout and hit are valid after edge N.
- Same-port read during write is read-first: dout shows the old byte. The write is visible from the next access.
- Cross-port read of an address being written in the same cycle also returns the old byte.
- Write collision (wea and web asserted, addra == addrb): port A's data is stored. The byte-valid bit is set once.
- Valid-bit updates:
  - A write on either port sets the byte-valid bit of that address.
  - line_valid[n] rises on the edge at which the last missing byte of line n is written.
- hita/hitb sample line_valid of the addressed line before the current edge's updates. A write to the last missing byte therefore does not produce a hit in the same access; the next access does.
- flush:
  - Clears all byte-valid bits on the edge where it is sampled.
  - Data is retained.
  - hita/hitb for accesses in the flush cycle report the pre-flush state.
  - If a write coincides with flush, flush clears everything first, then that write's byte-valid bit is set. That line is not valid until its other 15 bytes are rewritten.
- rst has priority over flush and over writes to the valid state. A RAM data write in a reset cycle still stores its data.
- Addresses are always 9 bits, with no out-of-range case. Line 31 covers 0x1F0–0x1FF.
- There is no state machine beyond the valid array. The block has no handshake and is always ready.

Test Plan:
- Reset, then read addra=0x000 -> hita=0, line_valid=0x00000000, douta=0x00 held until first read completes.
- Port B writes 0x10+i to addresses 0x020..0x02F on 16 consecutive cycles:
  - line_valid[2] is 0 after the 15th write and 1 after the 16th.
  - A following port A read of 0x025 gives douta=0x15, hita=1.
- Same cycle: wea=1 and web=1 at 0x1FF, dina=0xAA, dinb=0x55 -> next read of 0x1FF returns 0xAA. Only byte 15 of line 31 is marked valid; line_valid[31]=0.
- Read-first: 0x040 holds 0x11. Port A writes 0x22 to 0x040 while port B reads 0x040 -> doutb=0x11. The next port B read returns 0x22.
- Fill line 2 fully, then assert flush for one cycle:
  - line_valid=0 afterwards.
  - A read of 0x025 returns 0x15 with hita=0.
  - A port B write to 0x020 in the flush cycle leaves only byte 0 of line 2 valid.
- Fill line 5, assert rst mid-operation -> douta/doutb/hita/hitb=0 and line_valid=0 on the next cycle. Data at 0x050 is still readable.
